// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one 16-bit combinational ALU among NUM_REQ requesters. A round-robin
//   grant picks one request and registers its operands and opcode. Those registers
//   drive the ALU. The registered result is returned with a valid/ready handshake.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   req_valid     per-requester request strobe
//   req_ready     one-hot accept, only in IDLE
//   req_x, req_y  16-bit operands, requester i at [16*i+:16]
//   req_op        3-bit ALU control, requester i at [3*i+:3]
//   alu_x/alu_y/alu_control  registered drive to the shared ALU
//   alu_res       combinational ALU result
//   rsp_valid/rsp_ready      result handshake
//   rsp_id, rsp_res, rsp_zero  owner, registered result, result-is-zero flag
module alu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [16*NUM_REQ-1:0] req_x,
  input  logic [16*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [15:0]          alu_x,
  output logic [15:0]          alu_y,
  output logic [2:0]           alu_control,
  input  logic [15:0]          alu_res,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_res,
  output logic                 rsp_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [15:0]     x_q, y_q;
  logic [2:0]      op_q;
  logic [ID_W-1:0] id_q;
  logic [15:0]     rsp_res_q;
  logic            rsp_zero_q;
  logic [ID_W-1:0] rsp_id_q;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] ptr_nxt;
  logic [15:0]     sel_x, sel_y;
  logic [2:0]      sel_op;
  logic            grant;

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and take the first valid requester.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Operand mux with constant slices so no variable part-selects are needed.
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_x  = req_x[16*i +: 16];
        sel_y  = req_y[16*i +: 16];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

  always_comb begin
    if (winner == ID_W'(NUM_REQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = winner + ID_W'(1);
    end
  end

  assign grant = (state_q == StIdle) && found;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (found) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      if (grant) begin
        x_q      <= sel_x;
        y_q      <= sel_y;
        op_q     <= sel_op;
        id_q     <= winner;
        rr_ptr_q <= ptr_nxt;
      end
      if (state_q == StExec) begin
        rsp_res_q  <= alu_res;
        rsp_zero_q <= (alu_res == 16'h0000);
        rsp_id_q   <= id_q;
      end
    end
  end

  // ALU drive comes straight from the operand registers, so it holds between uses.
  assign alu_x       = x_q;
  assign alu_y       = y_q;
  assign alu_control = op_q;

  assign rsp_valid = (state_q == StResp);
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomised bench for alu_rr_arbiter: a transaction-level model predicts each grant
// and pushes the expected response; a monitor checks responses against the queue.
module tb_alu_rr_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_x, req_y;
  logic [3*N-1:0]  req_op;
  logic [15:0]     alu_x, alu_y, alu_res;
  logic [2:0]      alu_control;
  logic            rsp_valid, rsp_ready, rsp_zero;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_res;

  alu_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_op      (req_op),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_control (alu_control),
    .alu_res     (alu_res),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_res     (rsp_res),
    .rsp_zero    (rsp_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU the arbiter drives.
  function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return ~x;
      3'd3:    return x << y[3:0];
      3'd4:    return x >> y[3:0];
      3'd5:    return x & y;
      3'd6:    return x | y;
      default: return {15'b0, ($signed(x) < $signed(y))};
    endcase
  endfunction

  always_comb alu_res = alu_fn(alu_x, alu_y, alu_control);

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ptr = 0;
  bit          inflight = 0;
  int          grant_cyc = 0;
  int          release_cyc = -1;
  logic [15:0] last_x = '0, last_y = '0;
  logic [2:0]  last_op = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // Monitor: response timing and content against the expected queue.
  always @(negedge clk) begin
    bit exp_v;
    if (!rst) begin
      exp_v = inflight && (cyc >= grant_cyc + 2);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (rsp_valid && exp_v && q.size() > 0) begin
        check("rsp_id", 32'(rsp_id), 32'(q[0].id));
        check("rsp_res", 32'(rsp_res), 32'(q[0].res));
        check("rsp_zero", 32'(rsp_zero), 32'(q[0].res == 16'h0));
        if (rsp_ready) begin
          void'(q.pop_front());
          inflight    = 0;
          release_cyc = cyc;
        end
      end
    end
  end

  // Reference model: who should be granted this cycle, and what it should return.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           win;
    exp_t         e;
    #1;
    if (rst) begin
      q.delete();
      inflight = 0;
      ptr      = 0;
      last_x   = '0;
      last_y   = '0;
      last_op  = '0;
    end else begin
      check("alu_x", 32'(alu_x), 32'(last_x));
      check("alu_y", 32'(alu_y), 32'(last_y));
      check("alu_control", 32'(alu_control), 32'(last_op));
      exp_rdy = '0;
      win     = -1;
      if (!inflight && release_cyc != cyc) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && req_valid[(ptr + k) % N]) win = (ptr + k) % N;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (win >= 0) begin
        last_x    = req_x[16*win +: 16];
        last_y    = req_y[16*win +: 16];
        last_op   = req_op[3*win +: 3];
        e.id      = 2'(win);
        e.res     = alu_fn(last_x, last_y, last_op);
        q.push_back(e);
        inflight  = 1;
        grant_cyc = cyc;
        ptr       = (win + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                       input logic [2:0] op);
    req_x[16*id +: 16] = x;
    req_y[16*id +: 16] = y;
    req_op[3*id +: 3]  = op;
    req_valid          = '0;
    req_valid[id]      = 1'b1;
    step();
    req_valid = '0;
    repeat (3) step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Single add from requester 0.
    issue(0, 16'd5, 16'd3, 3'd0);

    // All requesters valid: rotating grants.
    req_x     = {$urandom(), $urandom()};
    req_y     = {$urandom(), $urandom()};
    req_op    = 12'($urandom());
    req_valid = '1;
    repeat (15) step();
    req_valid = '0;
    repeat (3) step();

    // Zero result, then wrap-around subtract.
    issue(2, 16'd7, 16'd7, 3'd1);
    issue(2, 16'd0, 16'd1, 3'd1);

    // Backpressure in RESP.
    rsp_ready = 1'b0;
    issue(1, 16'h1234, 16'h0101, 3'd0);
    repeat (3) step();
    rsp_ready = 1'b1;
    repeat (3) step();

    // Reset during EXEC, then lowest valid index wins.
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1010;
    step();
    req_valid = '0;
    repeat (3) step();

    // Reset during RESP.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1100;
    step();
    req_valid = '0;
    repeat (3) step();

    // Every opcode on one operand pair.
    for (int op = 0; op < 8; op++) issue(0, 16'h00F0, 16'd4, 3'(op));

    // Random traffic with occasional backpressure and reset.
    for (int i = 0; i < 600; i++) begin
      req_valid = 4'($urandom());
      req_x     = {$urandom(), $urandom()};
      req_y     = {$urandom(), $urandom()};
      req_op    = 12'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 79) == 0);
      step();
    end

    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    check("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
